// File: rtl/am2940_addr_word_datapath.sv
// Am2940-style address/word datapath: address and word registers/counters, control register,
// carries, readback and DONE. Define AM2940_DONE_REG_EN for a registered, sticky done flag.
module am2940_addr_word_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  input  logic             plar,
  input  logic             plwr,
  input  logic             plcr,
  input  logic             plac,
  input  logic             plwc,
  input  logic             sela,
  input  logic             selw,
  input  logic [1:0]       seld,
  input  logic             ena,
  input  logic             inca,
  input  logic             deca,
  input  logic             resw,
  input  logic             enw,
  input  logic             incw,
  input  logic             decw,
  input  logic             oedata,
  input  logic             aci_n,
  input  logic             wci_n,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] d_out,
  output logic             d_oe,
  output logic [2:0]       cr,
  output logic             aco_n,
  output logic             wco_n,
  output logic             done
);

  localparam int unsigned CRW = 3;
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] ar, ac, wr, wc;
  logic             a_cnt, w_cnt;
  logic             a_up, a_dn, w_up, w_dn;
  logic             done_cond;

  // Count qualifiers: enabled, carry-in asserted, and exactly one direction.
  assign a_up  = inca & ~deca;
  assign a_dn  = deca & ~inca;
  assign w_up  = incw & ~decw;
  assign w_dn  = decw & ~incw;
  assign a_cnt = ena & ~aci_n & (a_up | a_dn);
  assign w_cnt = enw & ~wci_n & (w_up | w_dn);

  // Address, word and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar <= ZERO;
      ac <= ZERO;
      wr <= ZERO;
      wc <= ZERO;
      cr <= 3'b000;
    end else begin
      if (plcr) cr <= d_in[CRW-1:0];
      if (plar) ar <= d_in;
      if (plwr) wr <= d_in;

      if (plac)       ac <= sela ? ar : d_in;
      else if (a_cnt) ac <= a_up ? ac + ONE : ac - ONE;

      if (resw)       wc <= ZERO;
      else if (plwc)  wc <= selw ? wr : d_in;
      else if (w_cnt) wc <= w_up ? wc + ONE : wc - ONE;
    end
  end

  assign addr = ac;
  assign d_oe = oedata;

  // Carry-outs flag a counter sitting at its terminal value in the active direction.
  always_comb begin
    aco_n = 1'b1;
    wco_n = 1'b1;
    if (ena && !aci_n && ((a_up && ac == ALL_ONES) || (a_dn && ac == ZERO))) aco_n = 1'b0;
    if (enw && !wci_n && ((w_up && wc == ALL_ONES) || (w_dn && wc == ZERO))) wco_n = 1'b0;
  end

  always_comb begin
    d_out = ZERO;
    if (oedata) begin
      if (seld[1])      d_out = {{(WIDTH-CRW){1'b1}}, cr};
      else if (seld[0]) d_out = wc;
      else              d_out = ac;
    end
  end

  // Transfer-complete condition selected by the control register mode bits.
  always_comb begin
    done_cond = 1'b0;
    case (cr[1:0])
      2'b00:   done_cond = (wc == ONE);
      2'b01:   done_cond = (wc == wr - ONE);
      2'b10:   done_cond = (ac == wr);
      default: done_cond = (wc == ALL_ONES);
    endcase
  end

`ifdef AM2940_DONE_REG_EN
  logic done_q;

  // Sticky until a new transfer is set up by a counter or control load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           done_q <= 1'b0;
    else if (plac || plwc || resw || plcr) done_q <= 1'b0;
    else                                  done_q <= done_q | done_cond;
  end

  assign done = done_q;
`else
  assign done = done_cond;
`endif

endmodule

// File: tb/tb_am2940_addr_word_datapath.sv
// Directed self-checking bench for am2940_addr_word_datapath (WIDTH=8).
module tb_am2940_addr_word_datapath;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] d_in;
  logic             plar, plwr, plcr, plac, plwc, sela, selw;
  logic [1:0]       seld;
  logic             ena, inca, deca, resw, enw, incw, decw, oedata, aci_n, wci_n;
  logic [WIDTH-1:0] addr, d_out;
  logic             d_oe, aco_n, wco_n, done;
  logic [2:0]       cr;

  int total = 0;
  int bad   = 0;

  am2940_addr_word_datapath #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in),
    .plar(plar), .plwr(plwr), .plcr(plcr), .plac(plac), .plwc(plwc),
    .sela(sela), .selw(selw), .seld(seld),
    .ena(ena), .inca(inca), .deca(deca),
    .resw(resw), .enw(enw), .incw(incw), .decw(decw),
    .oedata(oedata), .aci_n(aci_n), .wci_n(wci_n),
    .addr(addr), .d_out(d_out), .d_oe(d_oe), .cr(cr),
    .aco_n(aco_n), .wco_n(wco_n), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    d_in = '0; plar = 0; plwr = 0; plcr = 0; plac = 0; plwc = 0;
    sela = 0; selw = 0; seld = 2'b00; ena = 0; inca = 0; deca = 0;
    resw = 0; enw = 0; incw = 0; decw = 0; oedata = 0; aci_n = 1; wci_n = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_wc(input string tag, input logic [7:0] exp);
    seld = 2'b01; oedata = 1; #1;
    chk(tag, 16'(d_out), 16'(exp));
    oedata = 0; seld = 2'b00; #1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #12;
    chk("rst_addr",  16'(addr),  16'h00);
    chk("rst_dout",  16'(d_out), 16'h00);
    chk("rst_doe",   16'(d_oe),  16'h0);
    chk("rst_aco",   16'(aco_n), 16'h1);
    chk("rst_wco",   16'(wco_n), 16'h1);
    chk("rst_done",  16'(done),  16'h0);
    chk("rst_cr",    16'(cr),    16'h0);
    rst_n = 1;
    tick();

    // Mid-count asynchronous reset.
    d_in = 8'h37; plac = 1; tick(); idle();
    chk("ac_37", 16'(addr), 16'h37);
    ena = 1; inca = 1; aci_n = 0; tick();
    chk("ac_38", 16'(addr), 16'h38);
    #2 rst_n = 0; #1;
    chk("arst_addr", 16'(addr),  16'h00);
    chk("arst_aco",  16'(aco_n), 16'h1);
    chk("arst_done", 16'(done),  16'h0);
    idle(); tick(); rst_n = 1; tick();
    chk("arst_hold", 16'(addr), 16'h00);

    // Load AR and AC together, count up 3, reload from AR.
    d_in = 8'h40; plar = 1; plac = 1; sela = 0; tick(); idle();
    ena = 1; inca = 1; aci_n = 0;
    repeat (3) tick();
    idle();
    chk("count_43", 16'(addr), 16'h43);
    plac = 1; sela = 1; d_in = 8'h99; tick(); idle();
    chk("reload_ar", 16'(addr), 16'h40);
    seld = 2'b00; oedata = 1; #1;
    chk("rb_ac", 16'(d_out), 16'h40);
    chk("rb_doe", 16'(d_oe), 16'h1);
    idle(); #1;

    // Word mode 00 (CR=000 after reset).
    d_in = 8'h03; plwc = 1; tick(); idle();
    enw = 1; decw = 1; wci_n = 0;
    repeat (2) tick();
    read_wc("wc_1", 8'h01);
`ifdef AM2940_DONE_REG_EN
    chk("m00_done_wc1", 16'(done), 16'h0);
`else
    chk("m00_done_wc1", 16'(done), 16'h1);
`endif
    tick();
    read_wc("wc_0", 8'h00);
`ifdef AM2940_DONE_REG_EN
    chk("m00_done_wc0", 16'(done), 16'h1);
`else
    chk("m00_done_wc0", 16'(done), 16'h0);
`endif
    chk("wco_at_0", 16'(wco_n), 16'h0);
    idle(); #1;
    chk("wco_idle", 16'(wco_n), 16'h1);

    // Address wrap and carry, both directions.
    d_in = 8'hFF; plac = 1; tick(); idle();
    ena = 1; inca = 1; aci_n = 0; #1;
    chk("aco_ff", 16'(aco_n), 16'h0);
    tick();
    chk("wrap_up", 16'(addr), 16'h00);
    idle();
    d_in = 8'hFF; plac = 1; tick(); idle();
    ena = 1; inca = 1; aci_n = 1; tick();
    chk("hold_aci", 16'(addr), 16'hFF);
    chk("aco_aci1", 16'(aco_n), 16'h1);
    idle();
    d_in = 8'h00; plac = 1; tick(); idle();
    ena = 1; deca = 1; aci_n = 0; #1;
    chk("aco_00dn", 16'(aco_n), 16'h0);
    tick();
    chk("wrap_dn", 16'(addr), 16'hFF);
    idle();
    ena = 1; inca = 1; deca = 1; aci_n = 0; tick();
    chk("hold_both", 16'(addr), 16'hFF);
    idle();

    // resw beats plwc.
    d_in = 8'h55; plwc = 1; tick(); idle();
    read_wc("wc_55", 8'h55);
    d_in = 8'h55; resw = 1; plwc = 1; tick(); idle();
    seld = 2'b01; oedata = 1; #1;
    chk("prio_wc",  16'(d_out), 16'h00);
    chk("prio_doe", 16'(d_oe),  16'h1);
    oedata = 0; #1;
    chk("oe_off", 16'(d_out), 16'h00);
    idle();

    // Control register and its readback; mode 10.
    d_in = 8'h02; plcr = 1; tick(); idle();
    chk("cr_010", 16'(cr), 16'h2);
    seld = 2'b10; oedata = 1; #1;
    chk("rb_cr", 16'(d_out), 16'hFA);
    idle();
    d_in = 8'h10; plwr = 1; tick(); idle();
    d_in = 8'h0E; plac = 1; tick(); idle();
    ena = 1; inca = 1; aci_n = 0; #1;
    chk("m10_0e", 16'(done), 16'h0);
    tick();
    chk("m10_0f", 16'(done), 16'h0);
    tick();
    chk("m10_addr10", 16'(addr), 16'h10);
`ifdef AM2940_DONE_REG_EN
    chk("m10_10", 16'(done), 16'h0);
`else
    chk("m10_10", 16'(done), 16'h1);
`endif
    tick();
    chk("m10_addr11", 16'(addr), 16'h11);
`ifdef AM2940_DONE_REG_EN
    chk("m10_11", 16'(done), 16'h1);
    idle(); tick();
    chk("m10_sticky", 16'(done), 16'h1);
`else
    chk("m10_11", 16'(done), 16'h0);
    idle();
`endif
    d_in = 8'h00; plac = 1; tick(); idle();
    chk("m10_clr", 16'(done), 16'h0);

    // Mode 01: WC == WR-1 (WR=0x10).
    d_in = 8'h01; plcr = 1; tick(); idle();
    d_in = 8'h0F; plwc = 1; tick(); idle();
    tick();
    chk("m01_done", 16'(done), 16'h1);

    // Mode 11: WC == all ones, via WR load and selw.
    d_in = 8'h03; plcr = 1; tick(); idle();
    d_in = 8'hFF; plwr = 1; tick(); idle();
    plwc = 1; selw = 1; d_in = 8'h00; tick(); idle();
    tick();
    read_wc("wc_ff", 8'hFF);
    chk("m11_done", 16'(done), 16'h1);
    d_in = 8'h00; plwc = 1; tick(); idle();
    tick();
    chk("m11_nodone", 16'(done), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/am2940_addr_word_datapath.md
Name: am2940_addr_word_datapath

Overview:
- Sequential datapath directly downstream of instruction_decoder in the Am2940-style DMA address generator.
- Consumes the decoder's one-hot-ish control strobes (plar, plwr, sela, selw, plcr, seld, plac, ena, inca, deca, resw, plwc, enw, incw, decw, oedata).
- Holds the address register/counter, word register/counter and control register; drives the address bus, data readback, carry outputs and DONE.
- The control register value is fed back to the decoder's CR input.

Parameters:
- WIDTH, 8, width of address/word registers, counters and data bus.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- d_in  input  WIDTH  data bus in (load source)
- plar, plwr, plcr, plac, plwc  input  1 each  parallel-load strobes from decoder
- sela, selw  input  1 each  counter load source: 1 = register, 0 = d_in
- seld  input  2  readback select
- ena, inca, deca  input  1 each  address count enable / direction
- resw, enw, incw, decw  input  1 each  word counter reset / enable / direction
- oedata  input  1  data readback enable
- aci_n  input  1  address carry-in, active low, gates address counting
- wci_n  input  1  word carry-in, active low, gates word counting
- addr  output  WIDTH  address counter value
- d_out  output  WIDTH  readback data
- d_oe  output  1  d_out valid/drive enable (= oedata)
- cr  output  3  control register, to decoder CR
- aco_n  output  1  address carry-out, active low
- wco_n  output  1  word carry-out, active low
- done  output  1  transfer-complete flag

Behaviour:
- Reset (async, rst_n=0): AR, AC, WR, WC = 0; CR = 3'b000; addr=0, d_out=0, d_oe=0, aco_n=1, wco_n=1, done=0. Reset mid-count aborts immediately; counting resumes only after reset release and a new decoder command.
- All registers update on the rising edge of clk.
- CR: plcr=1 -> CR <= d_in[2:0].
- AR: plar=1 -> AR <= d_in.
- AC, in priority order:
  - plac=1 -> AC <= sela ? AR : d_in. When plar and plac are both set with sela=0, AR and AC both take d_in in the same cycle.
  - else ena=1 and aci_n=0 and exactly one of inca/deca set -> AC <= AC±1, modulo 2^WIDTH (wraps FF->00 inc, 00->FF dec).
  - inca=deca=1, inca=deca=0, or aci_n=1 -> hold.
- WR: plwr=1 -> WR <= d_in.
- WC, in priority order:
  - resw=1 -> WC <= 0.
  - else plwc=1 -> WC <= selw ? WR : d_in.
  - else enw=1 and wci_n=0 and exactly one of incw/decw -> WC <= WC±1, modulo 2^WIDTH.
  - otherwise hold.
- aco_n = 0 when ena=1, aci_n=0, and AC is terminal: all-ones with inca, zero with deca. Otherwise 1. Combinational.
- wco_n: same rule for the word counter, using enw/incw/decw/WC.
- d_out (combinational, 0 when oedata=0):
  - seld=1x -> {ones, CR}
  - seld=01 -> WC
  - seld=00 -> AC
- d_oe = oedata.
- done, by mode CR[1:0] (combinational from current register values):
  - 00 -> WC==1
  - 01 -> WC==WR-1 (modulo)
  - 10 -> AC==WR
  - 11 -> WC==all-ones
- CR[2] is not interpreted here; count direction comes only from inca/deca.

Optional Feature:
- Macro: AM2940_DONE_REG_EN.
- Defined: done is registered, asserting one clock after the condition holds. It is also sticky: it stays 1 until the next plac, plwc, resw or plcr cycle, and clears on reset.
- Undefined: done is combinational as specified in Behaviour.

Test Plan:
- Reset: assert rst_n=0 mid-count with AC=0x37 -> addr=0, all registers 0, done=0, aco_n=1 immediately, without waiting for a clock edge.
- Load address:
  - Stimulus: d_in=0x40, plar=1, plac=1, sela=0, one clock.
  - Count: ena=1, inca=1, aci_n=0 for 3 clocks.
  - Required: addr=0x43, AR=0x40.
  - Then plac=1, sela=1 -> addr=0x40.
- Word mode 00:
  - Stimulus: CR=000, WC loaded to 3, enw=1, decw=1 for 2 clocks.
  - Required: WC=1, done=1.
  - One more clock: WC=0, done=0.
- Wrap and carry: AC=0xFF, ena=1, inca=1, aci_n=0 -> aco_n=0 this cycle, addr=0x00 next cycle. With aci_n=1 the counter holds at 0xFF.
- Priority: resw=1 and plwc=1 together with d_in=0x55 -> WC=0. Readback with seld=01, oedata=1 -> d_out=0x00, d_oe=1.
- Mode 10: CR=010, WR=0x10, AC counting up from 0x0E -> done=1 exactly when addr=0x10. With AM2940_DONE_REG_EN defined, done rises one clock later and stays 1 until plac.
